// File: rtl/vdp_cpu_port.sv
// CPU-side port of a TMS9918-class VDP: control-port latch, register file, VRAM address counter,
// read-ahead buffer, sticky status and VRAM req/ack handshake. Optional int_n output under VDP_IRQ_OUT_EN.
module vdp_cpu_port #(
    parameter int ADDR_BITS  = 14,
    parameter int NUM_REGS   = 8,
    parameter int HI_REG_IDX = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_wr,
    input  logic                  io_rd,
    input  logic                  port_sel,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  vram_req,
    output logic                  vram_we,
    output logic [ADDR_BITS-1:0]  vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic                  vram_ack,
    input  logic [7:0]            vram_rdata,
    input  logic                  int_set,
    input  logic                  coll_set,
    input  logic                  fifth_set,
    input  logic [4:0]            fifth_num,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  overrun
`ifdef VDP_IRQ_OUT_EN
    ,
    output logic                  int_n
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]           state_reg;
    logic [7:0]           regs_reg [NUM_REGS];
    logic [ADDR_BITS-1:0] addr_reg;
    logic [ADDR_BITS-1:0] addr_load;
    logic [ADDR_BITS-1:0] vram_addr_reg;
    logic [7:0]           vram_wdata_reg;
    logic                 vram_we_reg;
    logic                 latch_reg;
    logic [7:0]           first_byte_reg;
    logic [7:0]           rbuf_reg;
    logic                 flag_f_reg;
    logic                 flag_c_reg;
    logic                 flag_5s_reg;
    logic [4:0]           fifth_reg;
    logic                 overrun_reg;

    // Write wins over a simultaneous read strobe.
    logic wr_en, rd_en, ctrl_wr, data_wr, ctrl_rd, data_rd;
    logic second_byte, reg_wr, addr_set, rd_setup, busy, ack_ok;
    logic issue_wr, issue_rd, dropped;

    assign wr_en       = io_wr;
    assign rd_en       = io_rd & ~io_wr;
    assign ctrl_wr     = wr_en & port_sel;
    assign data_wr     = wr_en & ~port_sel;
    assign ctrl_rd     = rd_en & port_sel;
    assign data_rd     = rd_en & ~port_sel;
    assign second_byte = ctrl_wr & latch_reg;
    assign reg_wr      = second_byte & din[7];
    assign addr_set    = second_byte & ~din[7];
    assign rd_setup    = addr_set & ~din[6];
    assign busy        = (state_reg == ST_REQ);
    assign ack_ok      = busy & vram_ack;
    assign issue_wr    = data_wr & ~busy;
    assign issue_rd    = (data_rd | rd_setup) & ~busy;
    assign dropped     = (data_wr | data_rd | rd_setup) & busy;

    generate
        if (ADDR_BITS > 14) begin : g_hi_addr
            assign addr_load = {regs_reg[HI_REG_IDX][ADDR_BITS-15:0], din[5:0], first_byte_reg};
        end else begin : g_lo_addr
            assign addr_load = {din[5:0], first_byte_reg};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            vram_we_reg    <= 1'b0;
            vram_addr_reg  <= '0;
            vram_wdata_reg <= 8'h00;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue_wr) begin
                        state_reg      <= ST_REQ;
                        vram_we_reg    <= 1'b1;
                        vram_addr_reg  <= addr_reg;
                        vram_wdata_reg <= din;
                    end else if (issue_rd) begin
                        state_reg     <= ST_REQ;
                        vram_we_reg   <= 1'b0;
                        vram_addr_reg <= rd_setup ? addr_load : addr_reg;
                    end
                end
                default: begin
                    if (vram_ack)
                        state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg       <= '0;
            latch_reg      <= 1'b0;
            first_byte_reg <= 8'h00;
            rbuf_reg       <= 8'h00;
            overrun_reg    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_reg[i] <= 8'h00;
        end else begin
            if (addr_set)
                addr_reg <= addr_load;
            else if (ack_ok)
                addr_reg <= addr_reg + ADDR_BITS'(1);

            if (ctrl_wr)
                latch_reg <= ~latch_reg;
            else if (data_wr | data_rd | ctrl_rd)
                latch_reg <= 1'b0;

            if (ctrl_wr & ~latch_reg)
                first_byte_reg <= din;

            if (issue_wr)
                rbuf_reg <= din;
            else if (ack_ok & ~vram_we_reg)
                rbuf_reg <= vram_rdata;

            if (dropped)
                overrun_reg <= 1'b1;

            // Out-of-range register numbers simply match no entry.
            for (int i = 0; i < NUM_REGS; i++)
                if (reg_wr && (din[5:0] == 6'(i)))
                    regs_reg[i] <= first_byte_reg;
        end
    end

    // A set pulse coincident with the clearing read keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_f_reg  <= 1'b0;
            flag_c_reg  <= 1'b0;
            flag_5s_reg <= 1'b0;
            fifth_reg   <= 5'h00;
        end else begin
            flag_f_reg  <= int_set   | (flag_f_reg  & ~ctrl_rd);
            flag_c_reg  <= coll_set  | (flag_c_reg  & ~ctrl_rd);
            flag_5s_reg <= fifth_set | (flag_5s_reg & ~ctrl_rd);
            if (fifth_set && (!flag_5s_reg || ctrl_rd))
                fifth_reg <= fifth_num;
        end
    end

`ifdef VDP_IRQ_OUT_EN
    always_ff @(posedge clk) begin
        if (reset)
            int_n <= 1'b1;
        else
            int_n <= ~(flag_f_reg & regs_reg[1][5]);
    end
`endif

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_flat
            assign regs[gi*8 +: 8] = regs_reg[gi];
        end
    endgenerate

    assign dout       = port_sel ? {flag_f_reg, flag_5s_reg, flag_c_reg, flag_5s_reg ? fifth_reg : 5'h1F}
                                 : rbuf_reg;
    assign vram_req   = busy;
    assign vram_we    = vram_we_reg;
    assign vram_addr  = vram_addr_reg;
    assign vram_wdata = vram_wdata_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port: default 14-bit instance plus a 17-bit instance on shared stimulus.
module tb_vdp_cpu_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic        port_sel = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = 8'h00;
    logic        int_set = 1'b0;
    logic        coll_set = 1'b0;
    logic        fifth_set = 1'b0;
    logic [4:0]  fifth_num = 5'h00;

    logic [7:0]   dout, dout17;
    logic         vram_req, vram_we, vram_req17, vram_we17;
    logic [13:0]  vram_addr;
    logic [16:0]  vram_addr17;
    logic [7:0]   vram_wdata, vram_wdata17;
    logic [63:0]  regs;
    logic [127:0] regs17;
    logic         overrun, overrun17;
`ifdef VDP_IRQ_OUT_EN
    logic         int_n, int_n17;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_regs;

    vdp_cpu_port dut (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .port_sel(port_sel), .din(din),
        .dout(dout), .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .int_set(int_set), .coll_set(coll_set), .fifth_set(fifth_set), .fifth_num(fifth_num),
        .regs(regs), .overrun(overrun)
`ifdef VDP_IRQ_OUT_EN
        , .int_n(int_n)
`endif
    );

    vdp_cpu_port #(.ADDR_BITS(17), .NUM_REGS(16), .HI_REG_IDX(14)) dut17 (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .port_sel(port_sel), .din(din),
        .dout(dout17), .vram_req(vram_req17), .vram_we(vram_we17), .vram_addr(vram_addr17),
        .vram_wdata(vram_wdata17), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .int_set(int_set), .coll_set(coll_set), .fifth_set(fifth_set), .fifth_num(fifth_num),
        .regs(regs17), .overrun(overrun17)
`ifdef VDP_IRQ_OUT_EN
        , .int_n(int_n17)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl_wr(input logic [7:0] b);
        port_sel = 1'b1; din = b; io_wr = 1'b1;
        tick;
        io_wr = 1'b0;
        $display("ctrl write %02h", b);
    endtask

    task automatic data_wr(input logic [7:0] b);
        port_sel = 1'b0; din = b; io_wr = 1'b1;
        tick;
        io_wr = 1'b0;
        $display("data write %02h", b);
    endtask

    task automatic ack_cycle(input logic [7:0] rd);
        vram_rdata = rd; vram_ack = 1'b1;
        tick;
        vram_ack = 1'b0;
        $display("vram ack rdata %02h", rd);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        port_sel = 1'b0; #1;
        vectors++; if (regs !== 64'h0) begin miscompares++; $display("FAIL reset_regs got %h want 0", regs); end
        vectors++; if (vram_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", vram_req); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_buf got %h want 00", dout); end
        port_sel = 1'b1; #1;
        vectors++; if (dout !== 8'h1F) begin miscompares++; $display("FAIL reset_status got %h want 1F", dout); end
`ifdef VDP_IRQ_OUT_EN
        vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL reset_int_n got %b want 1", int_n); end
`endif
        $display("reset done");
    endtask

    task automatic test_reg_write;
        ctrl_wr(8'hE2); ctrl_wr(8'h81);
        vectors++; if (regs[15:8] !== 8'hE2) begin miscompares++; $display("FAIL reg1 got %h want E2", regs[15:8]); end
        ctrl_wr(8'h55); ctrl_wr(8'h8A);
        vectors++; if (regs !== 64'h0000_0000_0000_E200) begin miscompares++; $display("FAIL reg_oob got %h want E200", regs); end
        vectors++; if (regs17[87:80] !== 8'h55) begin miscompares++; $display("FAIL reg10_wide got %h want 55", regs17[87:80]); end
    endtask

    task automatic test_write_inc;
        ctrl_wr(8'h00); ctrl_wr(8'h40);
        vectors++; if (vram_req !== 1'b0) begin miscompares++; $display("FAIL wsetup_noreq got %b want 0", vram_req); end
        data_wr(8'hAA);
        vectors++; if ({vram_req, vram_we, vram_addr, vram_wdata} !== {1'b1, 1'b1, 14'h0000, 8'hAA})
            begin miscompares++; $display("FAIL wr0 got req=%b we=%b a=%h d=%h want 1 1 0000 AA", vram_req, vram_we, vram_addr, vram_wdata); end
        ack_cycle(8'h00);
        vectors++; if (vram_req !== 1'b0) begin miscompares++; $display("FAIL wr0_done got %b want 0", vram_req); end
        data_wr(8'hBB);
        vectors++; if ({vram_addr, vram_wdata} !== {14'h0001, 8'hBB})
            begin miscompares++; $display("FAIL wr1 got a=%h d=%h want 0001 BB", vram_addr, vram_wdata); end
        ack_cycle(8'h00);
        port_sel = 1'b0; io_rd = 1'b1; #1;
        vectors++; if (dout !== 8'hBB) begin miscompares++; $display("FAIL rd_after_wr got %h want BB", dout); end
        tick; io_rd = 1'b0;
        vectors++; if ({vram_req, vram_we, vram_addr} !== {1'b1, 1'b0, 14'h0002})
            begin miscompares++; $display("FAIL prefetch2 got req=%b we=%b a=%h want 1 0 0002", vram_req, vram_we, vram_addr); end
        ack_cycle(8'h77);
    endtask

    task automatic test_read_ahead;
        ctrl_wr(8'hFF); ctrl_wr(8'h3F);
        vectors++; if ({vram_req, vram_we, vram_addr} !== {1'b1, 1'b0, 14'h3FFF})
            begin miscompares++; $display("FAIL rsetup got req=%b we=%b a=%h want 1 0 3FFF", vram_req, vram_we, vram_addr); end
        ack_cycle(8'h12);
        port_sel = 1'b0; io_rd = 1'b1; #1;
        vectors++; if (dout !== 8'h12) begin miscompares++; $display("FAIL rd_buf got %h want 12", dout); end
        tick; io_rd = 1'b0;
        vectors++; if ({vram_req, vram_addr} !== {1'b1, 14'h0000})
            begin miscompares++; $display("FAIL wrap got req=%b a=%h want 1 0000", vram_req, vram_addr); end
        ack_cycle(8'h34);
        io_rd = 1'b1; #1;
        vectors++; if (dout !== 8'h34) begin miscompares++; $display("FAIL rd_buf2 got %h want 34", dout); end
        tick; io_rd = 1'b0;
        ack_cycle(8'h00);
    endtask

    task automatic test_status;
        int_set = 1'b1; tick; int_set = 1'b0;
        port_sel = 1'b1; io_rd = 1'b1; #1;
        vectors++; if (dout !== 8'h9F) begin miscompares++; $display("FAIL status_f got %h want 9F", dout); end
        tick;
        coll_set = 1'b1; #1;
        vectors++; if (dout !== 8'h1F) begin miscompares++; $display("FAIL status_clr got %h want 1F", dout); end
        tick; io_rd = 1'b0; coll_set = 1'b0; #1;
        vectors++; if (dout !== 8'h3F) begin miscompares++; $display("FAIL status_c_wins got %h want 3F", dout); end
        io_rd = 1'b1; tick; io_rd = 1'b0;
        fifth_num = 5'h07; fifth_set = 1'b1; tick; fifth_set = 1'b0; #1;
        vectors++; if (dout !== 8'h47) begin miscompares++; $display("FAIL status_5s got %h want 47", dout); end
        io_rd = 1'b1; tick; io_rd = 1'b0; #1;
        vectors++; if (dout !== 8'h1F) begin miscompares++; $display("FAIL status_5s_clr got %h want 1F", dout); end
        $display("status reads done");
    endtask

    task automatic test_overrun;
        ctrl_wr(8'h00); ctrl_wr(8'h40);
        data_wr(8'h5A);
        vectors++; if ({vram_req, vram_wdata} !== {1'b1, 8'h5A})
            begin miscompares++; $display("FAIL ovr_first got req=%b d=%h want 1 5A", vram_req, vram_wdata); end
        tick; tick;
        data_wr(8'h6B);
        vectors++; if ({overrun, vram_wdata, vram_addr} !== {1'b1, 8'h5A, 14'h0000})
            begin miscompares++; $display("FAIL ovr_drop got ovr=%b d=%h a=%h want 1 5A 0000", overrun, vram_wdata, vram_addr); end
        ctrl_wr(8'hE7); ctrl_wr(8'h84);
        vectors++; if (regs[39:32] !== 8'hE7) begin miscompares++; $display("FAIL ovr_regwr got %h want E7", regs[39:32]); end
        tick; tick; tick; tick;
        ack_cycle(8'h00);
        tick;
        vectors++; if ({vram_req, overrun} !== 2'b01)
            begin miscompares++; $display("FAIL ovr_single got req=%b ovr=%b want 0 1", vram_req, overrun); end
    endtask

    task automatic test_hi_addr;
        ctrl_wr(8'h05); ctrl_wr(8'h8E);
        ctrl_wr(8'h00); ctrl_wr(8'h40);
        data_wr(8'h01);
        vectors++; if (vram_addr17 !== 17'h14000) begin miscompares++; $display("FAIL hi_addr got %h want 14000", vram_addr17); end
        vectors++; if (vram_addr !== 14'h0000) begin miscompares++; $display("FAIL lo_addr got %h want 0000", vram_addr); end
        exp_regs = 64'h0;
        exp_regs[15:8]  = 8'hE2;
        exp_regs[39:32] = 8'hE7;
        vectors++; if (regs !== exp_regs) begin miscompares++; $display("FAIL hi_regs got %h want %h", regs, exp_regs); end
        ack_cycle(8'h00);
    endtask

`ifdef VDP_IRQ_OUT_EN
    task automatic test_irq;
        ctrl_wr(8'h20); ctrl_wr(8'h81);
        int_set = 1'b1; tick; int_set = 1'b0;
        vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL irq_lag got %b want 1", int_n); end
        tick;
        vectors++; if (int_n !== 1'b0) begin miscompares++; $display("FAIL irq_assert got %b want 0", int_n); end
    endtask
`endif

    task automatic test_reset_midreq;
        ctrl_wr(8'h00); ctrl_wr(8'h40);
        data_wr(8'h11);
        vectors++; if (vram_req !== 1'b1) begin miscompares++; $display("FAIL mid_req got %b want 1", vram_req); end
        ctrl_wr(8'h99);
        reset = 1'b1; vram_ack = 1'b1;
        tick;
        reset = 1'b0; vram_ack = 1'b0;
        vectors++; if ({vram_req, overrun} !== 2'b00)
            begin miscompares++; $display("FAIL mid_reset got req=%b ovr=%b want 0 0", vram_req, overrun); end
`ifdef VDP_IRQ_OUT_EN
        vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL mid_int_n got %b want 1", int_n); end
`endif
        ctrl_wr(8'hC3); ctrl_wr(8'h82);
        vectors++; if (regs !== 64'h0000_0000_00C3_0000)
            begin miscompares++; $display("FAIL latch_cleared got %h want C30000", regs); end
    endtask

    initial begin
        test_reset;
        test_reg_write;
        test_write_inc;
        test_read_ahead;
        test_status;
        test_overrun;
        test_hi_addr;
`ifdef VDP_IRQ_OUT_EN
        test_irq;
`endif
        test_reset_midreq;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
